// File: rtl/stopwatch.sv
// stopwatch: counts clock ticks between a start event and a stop event and
// reports the elapsed whole seconds, floor(ticks/FREQ), saturating at
// 2^MAX_TIME-1.
//
// Ports:
//   stopwatch_clock     in   system clock, rising edge
//   stopwatch_rstn      in   asynchronous active-low reset
//   stopwatch_start     in   begins a measurement (IDLE/DONE)
//   stopwatch_stop      in   ends a measurement (RUN)
//   stopwatch_clear     in   synchronous return to IDLE, highest priority
//   stopwatch_time      out  elapsed seconds; live in RUN, frozen in DONE
//   stopwatch_running   out  high while in RUN
//   stopwatch_valid     out  one-cycle pulse after the stop edge
//   stopwatch_overflow  out  sticky, seconds count saturated
//
// state | meaning
// IDLE  | no measurement, outputs cleared
// RUN   | counting ticks
// DONE  | result captured and held
module stopwatch #(
  parameter int FREQ     = 5,
  parameter int MAX_TIME = 10
) (
  input  logic                stopwatch_clock,
  input  logic                stopwatch_rstn,
  input  logic                stopwatch_start,
  input  logic                stopwatch_stop,
  input  logic                stopwatch_clear,
  output logic [MAX_TIME-1:0] stopwatch_time,
  output logic                stopwatch_running,
  output logic                stopwatch_valid,
  output logic                stopwatch_overflow
);

  localparam logic [12:0]         PRE_LAST = 13'(FREQ - 1);
  localparam logic [MAX_TIME-1:0] SEC_MAX  = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q;
  logic [12:0]         pre_q;
  logic [MAX_TIME-1:0] sec_q;
  logic                run_q;
  logic                valid_q;
  logic                ovf_q;

  always_ff @(posedge stopwatch_clock or negedge stopwatch_rstn) begin
    if (!stopwatch_rstn) begin
      state_q <= IDLE;
      pre_q   <= '0;
      sec_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (stopwatch_clear) begin
        state_q <= IDLE;
        pre_q   <= '0;
        sec_q   <= '0;
        run_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            // stop is ignored here, so start wins a simultaneous stop
            if (stopwatch_start) begin
              state_q <= RUN;
              pre_q   <= '0;
              sec_q   <= '0;
              run_q   <= 1'b1;
              ovf_q   <= 1'b0;
            end
          end
          RUN: begin
            if (stopwatch_stop) begin
              // the stop edge itself is not a tick
              state_q <= DONE;
              run_q   <= 1'b0;
              valid_q <= 1'b1;
            end else if (pre_q == PRE_LAST) begin
              pre_q <= '0;
              if (sec_q == SEC_MAX) ovf_q <= 1'b1;
              else                  sec_q <= sec_q + 1'b1;
            end else begin
              pre_q <= pre_q + 13'd1;
            end
          end
          default: begin
            state_q <= IDLE;
            run_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign stopwatch_time     = sec_q;
  assign stopwatch_running  = run_q;
  assign stopwatch_valid    = valid_q;
  assign stopwatch_overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch.sv
module tb_stopwatch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       a_start, a_stop, a_clear;
  logic [9:0] a_time;
  logic       a_run, a_valid, a_ovf;
  logic       b_start, b_stop, b_clear;
  logic [3:0] b_time;
  logic       b_run, b_valid, b_ovf;

  stopwatch #(.FREQ(5), .MAX_TIME(10)) dut_a (
    .stopwatch_clock   (clk),
    .stopwatch_rstn    (rstn),
    .stopwatch_start   (a_start),
    .stopwatch_stop    (a_stop),
    .stopwatch_clear   (a_clear),
    .stopwatch_time    (a_time),
    .stopwatch_running (a_run),
    .stopwatch_valid   (a_valid),
    .stopwatch_overflow(a_ovf)
  );

  stopwatch #(.FREQ(1), .MAX_TIME(4)) dut_b (
    .stopwatch_clock   (clk),
    .stopwatch_rstn    (rstn),
    .stopwatch_start   (b_start),
    .stopwatch_stop    (b_stop),
    .stopwatch_clear   (b_clear),
    .stopwatch_time    (b_time),
    .stopwatch_running (b_run),
    .stopwatch_valid   (b_valid),
    .stopwatch_overflow(b_ovf)
  );

  typedef struct {
    string      tag;
    int         dut;
    logic [9:0] t;
    logic       r;
    logic       v;
    logic       o;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // expected seconds for N ticks
  function automatic int exp_sec(int n, int freq, int maxt);
    int s;
    s = n / freq;
    if (s > (1 << maxt) - 1) s = (1 << maxt) - 1;
    return s;
  endfunction

  task automatic push(string tag, int dut, int t, bit r, bit v, bit o);
    exp_t e;
    e.tag = tag; e.dut = dut; e.t = 10'(t); e.r = r; e.v = v; e.o = o;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [12:0] obs, expv;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) obs = {a_time, a_run, a_valid, a_ovf};
      else            obs = {6'b0, b_time, b_run, b_valid, b_ovf};
      expv = {e.t, e.r, e.v, e.o};
      checks++;
      assert (obs === expv) else begin
        failures++;
        $error("FAIL %s observed{time,run,valid,ovf}=%h expected=%h", e.tag, obs, expv);
      end
    end
  endtask

  task automatic chk(string tag, int dut, int t, bit r, bit v, bit o);
    push(tag, dut, t, r, v, o);
    drain();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start, n ticks, stop on DUT A
  task automatic meas_a(int n);
    a_start = 1'b1; step(); a_start = 1'b0;
    repeat (n) step();
    a_stop = 1'b1; step(); a_stop = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    a_start = 1'b0; a_stop = 1'b0; a_clear = 1'b0;
    b_start = 1'b0; b_stop = 1'b0; b_clear = 1'b0;
    #22;
    chk("reset_a", 0, 0, 0, 0, 0);
    chk("reset_b", 1, 0, 0, 0, 0);
    @(negedge clk); rstn = 1'b1;
    step();

    // basic N=10 -> 2
    a_start = 1'b1; step(); a_start = 1'b0;
    chk("run_entered", 0, 0, 1, 0, 0);
    repeat (5) step();
    chk("live_time_n5", 0, exp_sec(5, 5, 10), 1, 0, 0);
    repeat (5) step();
    a_stop = 1'b1; step(); a_stop = 1'b0;
    chk("n10_valid", 0, exp_sec(10, 5, 10), 0, 1, 0);
    step();
    chk("n10_valid_drop", 0, 2, 0, 0, 0);

    // boundaries
    meas_a(4);
    chk("n4_time0", 0, exp_sec(4, 5, 10), 0, 1, 0);
    meas_a(5);
    chk("n5_time1", 0, exp_sec(5, 5, 10), 0, 1, 0);
    repeat (20) step();
    chk("done_hold20", 0, 1, 0, 0, 0);

    // clear from DONE
    a_clear = 1'b1; step(); a_clear = 1'b0;
    chk("clear_done", 0, 0, 0, 0, 0);

    // start+stop together in IDLE: start wins
    a_start = 1'b1; a_stop = 1'b1; step(); a_start = 1'b0; a_stop = 1'b0;
    chk("idle_both_run", 0, 0, 1, 0, 0);
    repeat (3) step();
    // start alone in RUN still counts a tick
    a_start = 1'b1; step(); a_start = 1'b0;
    repeat (2) step();
    chk("start_in_run", 0, exp_sec(6, 5, 10), 1, 0, 0);
    a_start = 1'b1; a_stop = 1'b1; step(); a_start = 1'b0; a_stop = 1'b0;
    chk("run_both_done", 0, 1, 0, 1, 0);
    step();
    chk("run_both_drop", 0, 1, 0, 0, 0);

    // restart from DONE
    meas_a(10);
    chk("pre_restart", 0, 2, 0, 1, 0);
    step();
    a_start = 1'b1; step(); a_start = 1'b0;
    chk("restart_cleared", 0, 0, 1, 0, 0);
    repeat (7) step();
    a_stop = 1'b1; step(); a_stop = 1'b0;
    chk("restart_n7", 0, exp_sec(7, 5, 10), 0, 1, 0);
    step();
    chk("restart_drop", 0, 1, 0, 0, 0);

    // async reset mid-RUN at time 3
    a_start = 1'b1; step(); a_start = 1'b0;
    repeat (15) step();
    chk("pre_reset_t3", 0, 3, 1, 0, 0);
    #2 rstn = 1'b0; #1;
    chk("reset_immediate", 0, 0, 0, 0, 0);
    step();
    @(negedge clk); rstn = 1'b1;
    step();
    chk("reset_no_valid", 0, 0, 0, 0, 0);

    // sync clear mid-RUN at time 3
    a_start = 1'b1; step(); a_start = 1'b0;
    repeat (15) step();
    chk("pre_clear_t3", 0, 3, 1, 0, 0);
    a_clear = 1'b1; step(); a_clear = 1'b0;
    chk("clear_run", 0, 0, 0, 0, 0);
    step();
    chk("clear_no_valid", 0, 0, 0, 0, 0);

    // saturation on FREQ=1, MAX_TIME=4
    b_start = 1'b1; step(); b_start = 1'b0;
    repeat (15) step();
    chk("sat_t15_no_ovf", 1, 15, 1, 0, 0);
    step();
    chk("sat_ovf_set", 1, 15, 1, 0, 1);
    repeat (4) step();
    chk("sat_20_ticks", 1, exp_sec(20, 1, 4), 1, 0, 1);
    b_stop = 1'b1; step(); b_stop = 1'b0;
    chk("sat_stop_valid", 1, 15, 0, 1, 1);
    step();
    chk("sat_done_hold", 1, 15, 0, 0, 1);
    b_start = 1'b1; step(); b_start = 1'b0;
    chk("sat_restart", 1, 0, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch.md
Name: stopwatch

Overview:
- Elapsed-time measurer; the inverse of the countdown timer.
- The timer converts a seconds value into FREQ-scaled ticks and counts down. This block counts clock ticks between a start event and a stop event and reports the elapsed whole seconds, floor(ticks/FREQ).
- Sits beside the countdown timer on the same slow system clock. Used to measure the interval between external events and report it in the same seconds units the timer is loaded with.

Parameters:
- FREQ, 5, clock ticks per second; legal range 1..8191.
- MAX_TIME, 10, width of the seconds result; saturation value is 2^MAX_TIME-1.

Ports:
- stopwatch_clock  input  1  system clock; all state changes on its rising edge.
- stopwatch_rstn  input  1  asynchronous, active-low reset.
- stopwatch_start  input  1  level sampled each edge; begins a measurement.
- stopwatch_stop  input  1  level sampled each edge; ends a measurement.
- stopwatch_clear  input  1  synchronous clear to IDLE.
- stopwatch_time  output  MAX_TIME  elapsed whole seconds; live while running, frozen after stop.
- stopwatch_running  output  1  high while in RUN.
- stopwatch_valid  output  1  one-cycle pulse when a result is captured.
- stopwatch_overflow  output  1  sticky flag; seconds count saturated.

Behaviour:
- Reset (stopwatch_rstn low, asynchronous):
  - state goes to IDLE; prescaler = 0; seconds = 0.
  - stopwatch_time = 0, stopwatch_running = 0, stopwatch_valid = 0, stopwatch_overflow = 0.
  - Reset asserted mid-measurement discards the measurement; no valid pulse is produced.
- Internal registers:
  - 13-bit prescaler, 0..FREQ-1.
  - MAX_TIME-bit seconds counter, driven directly onto stopwatch_time.
- States: IDLE, RUN, DONE. stopwatch_running = (state == RUN), registered.
- Priority per edge: clear > state-specific rules.
  - clear asserted: state goes to IDLE; prescaler, seconds, valid and overflow go to 0. This applies from any state.
- IDLE:
  - start asserted: go to RUN; prescaler = 0; seconds = 0; overflow = 0.
  - stop is ignored, including when asserted in the same cycle as start (start wins).
- RUN:
  - stop asserted: go to DONE; seconds frozen; stopwatch_valid = 1 for the following cycle only. The stop edge does not count a tick.
  - start asserted without stop is ignored (no restart).
  - start and stop in the same cycle: stop wins.
  - Otherwise, one tick per edge:
    - if prescaler == FREQ-1, prescaler wraps to 0 and seconds increments;
    - else prescaler increments.
  - FREQ = 1: seconds increments on every tick.
- Saturation:
  - A wrap with seconds == 2^MAX_TIME-1 leaves seconds unchanged and sets overflow.
  - Overflow stays set until the next start or clear.
  - The prescaler keeps wrapping after saturation.
- DONE:
  - stopwatch_time holds the captured value; valid is low after its single pulse.
  - start asserted: same as the IDLE start (new measurement, overflow cleared).
  - stop is ignored.
- Timing definition: start sampled at edge s, stop sampled at edge e.
  - ticks N = e - s - 1.
  - stopwatch_time = min(floor(N/FREQ), 2^MAX_TIME-1).
  - stopwatch_valid is high between edges e and e+1.
- valid is a registered output; it never asserts in IDLE, and never on clear or reset.

Test Plan:
- FREQ=5, MAX_TIME=10: start at edge 0, stop at edge 11 (N=10) -> time=2, valid high for exactly one cycle after edge 11, running=0, overflow=0.
- Boundary, FREQ=5: stop at edge 5 (N=4) -> time=0. Stop at edge 6 (N=5) -> time=1. Time holds in DONE for 20 further cycles.
- Simultaneous events:
  - start and stop together in IDLE -> RUN entered, no valid.
  - start and stop together in RUN -> DONE with valid.
  - start alone in RUN -> counting continues uninterrupted.
- Saturation, FREQ=1, MAX_TIME=4: run 20 ticks -> time=15, overflow=1. Stop -> valid. Next start -> overflow=0, time=0.
- Reset and clear: assert stopwatch_rstn low mid-RUN at time=3 -> all outputs 0 immediately, IDLE, no valid. Repeat with clear -> same values at the next edge.
- Restart from DONE: after a result of 2, start then stop after N=7 with FREQ=5 -> time=1, one valid pulse per measurement.
